// File: rtl/seg_scan_display.sv
// Multiplexed common-anode 7-segment driver for the packed 8-digit time/alarm bus.
// The bus is snapshotted once per frame so a digit change mid-scan never tears the display.
module seg_scan_display #(
  parameter int NUM_DIGITS     = 8,
  parameter int DWELL          = 2,
  parameter int GAP            = 0,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                    clk_1khz,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP);

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW_AN ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0]            SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = ACTIVE_LOW_SEG;

  logic [IDX_W-1:0]      idx_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [3:0]            snap_code_reg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] snap_dp_reg;

  logic [3:0]            live_code [NUM_DIGITS];
  logic                  boundary;
  logic                  lit;
  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic [6:0]            glyph;
  logic [NUM_DIGITS-1:0] an_onehot;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_live
      assign live_code[gi] = digits[4*gi +: 4];
    end
    if (GAP == 0) begin : g_nogap
      assign lit = 1'b1;
    end else begin : g_gap
      assign lit = (cnt_reg >= CNT_GAP);
    end
  endgenerate

  // On the boundary edge the snapshot is still stale, so digit 0 comes straight off the bus.
  assign boundary  = (idx_reg == '0) && (cnt_reg == '0);
  assign cur_code  = boundary ? live_code[0] : snap_code_reg[idx_reg];
  assign cur_dp    = boundary ? dp[0] : snap_dp_reg[idx_reg];
  assign an_onehot = NUM_DIGITS'(1) << idx_reg;

  // Segment order {g,f,e,d,c,b,a}, 1 = lit.
  always_comb begin
    glyph = 7'h00;
    case (cur_code)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h40;
      default: glyph = 7'h00;
    endcase
  end

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg       <= '0;
      cnt_reg       <= '0;
      snap_code_reg <= '{default: 4'h0};
      snap_dp_reg   <= '0;
      an            <= AN_OFF;
      seg           <= SEG_OFF;
      dp_out        <= DP_OFF;
      frame_start   <= 1'b0;
    end else if (!en) begin
      idx_reg     <= '0;
      cnt_reg     <= '0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp_out      <= DP_OFF;
      frame_start <= 1'b0;
    end else begin
      if (boundary) begin
        snap_code_reg <= live_code;
        snap_dp_reg   <= dp;
      end
      frame_start <= boundary;
      if (lit) begin
        an     <= ACTIVE_LOW_AN ? ~an_onehot : an_onehot;
        seg    <= ACTIVE_LOW_SEG ? ~glyph : glyph;
        dp_out <= cur_dp ^ ACTIVE_LOW_SEG;
      end else begin
        an     <= AN_OFF;
        seg    <= SEG_OFF;
        dp_out <= DP_OFF;
      end
      if (cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: default instance plus a GAP=1/DWELL=4 instance on shared inputs,
// checked against a frame-position reference model, decode vectors and hand-written corner cases.
module tb_seg_scan_display;

  logic        clk_1khz = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] digits;
  logic [7:0]  dp;

  logic [6:0] seg0, seg1;
  logic       dp_out0, dp_out1;
  logic [7:0] an0, an1;
  logic       fs0, fs1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_1khz = ~clk_1khz;

  seg_scan_display dut (
    .clk_1khz(clk_1khz), .rst_n(rst_n), .en(en), .digits(digits), .dp(dp),
    .seg(seg0), .dp_out(dp_out0), .an(an0), .frame_start(fs0)
  );

  seg_scan_display #(.NUM_DIGITS(8), .DWELL(4), .GAP(1)) dut_gap (
    .clk_1khz(clk_1khz), .rst_n(rst_n), .en(en), .digits(digits), .dp(dp),
    .seg(seg1), .dp_out(dp_out1), .an(an1), .frame_start(fs1)
  );

  // Reference glyphs {g,f,e,d,c,b,a}, active-high, codes 0..F.
  logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h40, 7'h00};

  // Model: position within the frame is a single linear count since the last restart.
  int          dwell_p [2] = '{2, 4};
  int          gap_p   [2] = '{0, 1};
  int          mk      [2];
  logic [31:0] mcap    [2];
  logic [7:0]  mcapdp  [2];
  logic [7:0]  e_an    [2];
  logic [6:0]  e_seg   [2];
  logic        e_dp    [2];
  logic        e_fs    [2];

  task automatic model_dark(input int m);
    mk[m]    = 0;
    e_an[m]  = 8'hFF;
    e_seg[m] = 7'h7F;
    e_dp[m]  = 1'b1;
    e_fs[m]  = 1'b0;
  endtask

  task automatic model_edge(input int m);
    int per, pos, d, ph;
    logic [3:0] code;
    if (!rst_n || !en) begin
      model_dark(m);
    end else begin
      per = 8 * dwell_p[m];
      pos = mk[m] % per;
      if (pos == 0) begin
        mcap[m]   = digits;
        mcapdp[m] = dp;
      end
      d    = pos / dwell_p[m];
      ph   = pos % dwell_p[m];
      code = mcap[m][4*d +: 4];
      e_fs[m] = (pos == 0);
      if (ph >= gap_p[m]) begin
        e_an[m]  = ~(8'b1 << d);
        e_seg[m] = ~glyph_tbl[code];
        e_dp[m]  = ~mcapdp[m][d];
      end else begin
        e_an[m]  = 8'hFF;
        e_seg[m] = 7'h7F;
        e_dp[m]  = 1'b1;
      end
      mk[m] = mk[m] + 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m0_an",  {24'h0, an0},   {24'h0, e_an[0]});
    chk("m0_seg", {25'h0, seg0},  {25'h0, e_seg[0]});
    chk("m0_dp",  {31'h0, dp_out0}, {31'h0, e_dp[0]});
    chk("m0_fs",  {31'h0, fs0},   {31'h0, e_fs[0]});
    chk("m1_an",  {24'h0, an1},   {24'h0, e_an[1]});
    chk("m1_seg", {25'h0, seg1},  {25'h0, e_seg[1]});
    chk("m1_dp",  {31'h0, dp_out1}, {31'h0, e_dp[1]});
    chk("m1_fs",  {31'h0, fs1},   {31'h0, e_fs[1]});
  endtask

  task automatic step();
    @(posedge clk_1khz);
    model_edge(0);
    model_edge(1);
    #1;
    compare_model();
  endtask

  typedef struct packed {
    logic [31:0]     digits;
    logic [7:0]      dp;
    logic [7:0][6:0] exp_seg;   // active-high glyph per digit, [7] first
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{32'h12E34E56, 8'h00, {7'h06, 7'h5B, 7'h40, 7'h4F, 7'h66, 7'h40, 7'h6D, 7'h7D}};
    vecs[1] = '{32'h76543210, 8'hA5, {7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F}};
    vecs[2] = '{32'hFEDCBA98, 8'h5A, {7'h00, 7'h40, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F}};
    vecs[3] = '{32'hFFFFFFFF, 8'hFF, {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}};
    vecs[4] = '{32'h88888888, 8'h01, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}};

    rst_n  = 1'b1;
    en     = 1'b0;
    digits = 32'h0;
    dp     = 8'h0;

    // Async reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    model_dark(0);
    model_dark(1);
    compare_model();
    $display("reset: an=%h seg=%h dp_out=%b fs=%b", an0, seg0, dp_out0, fs0);
    step();
    step();

    // Scan order, then no-tearing: bus changes while digit 3 is lit.
    rst_n  = 1'b1;
    en     = 1'b1;
    digits = 32'h00000000;
    for (int c = 0; c < 48; c++) begin
      step();
      if (c == 0)  chk("t2_first_fs", {31'h0, fs0}, 32'h1);
      if (c == 1)  chk("t2_fs_once",  {31'h0, fs0}, 32'h0);
      if (c == 15) chk("t2_last_an",  {24'h0, an0}, 32'h7F);
      if (c == 16) chk("t2_repeat",   {24'h0, an0}, 32'hFE);
      if (c == 6)  digits = 32'h11111111;
      if (c == 10) chk("t4_old_digit5", {25'h0, seg0}, {25'h0, ~7'h3F});
      if (c == 26) chk("t4_new_digit5", {25'h0, seg0}, {25'h0, ~7'h06});
    end
    $display("scan/no-tear sequence: 48 cycles");

    // en drop at digit 5.
    for (int c = 0; c < 11; c++) step();
    chk("t6_en_pre_digit5", {24'h0, an0}, 32'hDF);
    en = 1'b0;
    step();
    chk("t6_en_dark", {24'h0, an0}, 32'hFF);
    en = 1'b1;
    step();
    chk("t6_en_fs", {31'h0, fs0}, 32'h1);
    chk("t6_en_an", {24'h0, an0}, 32'hFE);
    $display("en drop sequence done");

    // rst_n pulse at digit 5.
    for (int c = 0; c < 10; c++) step();
    chk("t6_rst_pre_digit5", {24'h0, an0}, 32'hDF);
    #2 rst_n = 1'b0;
    #1;
    model_dark(0);
    model_dark(1);
    compare_model();
    step();
    #1 rst_n = 1'b1;
    step();
    chk("t6_rst_fs", {31'h0, fs0}, 32'h1);
    chk("t6_rst_an", {24'h0, an0}, 32'hFE);
    $display("reset pulse sequence done");

    // Decode vectors; the bus is scrambled after the capture edge to prove the snapshot holds.
    for (int v = 0; v < 5; v++) begin
      en     = 1'b0;
      digits = vecs[v].digits;
      dp     = vecs[v].dp;
      step();
      en = 1'b1;
      for (int j = 0; j < 16; j++) begin
        int d;
        step();
        d = j / 2;
        chk("vec_seg", {25'h0, seg0},    {25'h0, ~vecs[v].exp_seg[d]});
        chk("vec_dp",  {31'h0, dp_out0}, {31'h0, ~vecs[v].dp[d]});
        chk("vec_an",  {24'h0, an0},     {24'h0, ~(8'b1 << d)});
        if (j == 0) begin
          digits = $urandom;
          dp     = 8'($urandom);
        end
      end
      $display("vec %0d digits=%h dp=%h applied", v, vecs[v].digits, vecs[v].dp);
    end

    // Random bus traffic with occasional enable drops.
    for (int c = 0; c < 400; c++) begin
      digits = $urandom;
      dp     = 8'($urandom);
      en     = ($urandom_range(0, 24) != 0);
      step();
    end
    $display("random traffic: 400 cycles");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
